sprite_register_scanner: RTL and testbench

Upstream feeder of the sprite print stage in the VGA console. It holds a small bank of 32-bit sprite registers written by the CPU side. On each active pixel strobe it scans the bank in index order and presents one enabled entry at a time on data_reg, together with the registered pixel coordinates. It stops on the first entry the print stage claims (printing high), and holds that entry until the line counter reports count_finished.

---
 rtl/sprite_register_scanner.sv | 174 +++++++++++++++++
 tb/tb_sprite_register_scanner.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_register_scanner.sv
// ----------------------------------------------------------------------------
// sprite_register_scanner: per-pixel priority scan of a CPU-written sprite bank
// feeding the sprite print stage.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sprite_register_scanner #(
  parameter int NUM_REGS   = 8,
  parameter int ADDR_W     = 3,
  parameter int size_x     = 10,
  parameter int size_y     = 9,
  parameter int ENABLE_BIT = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic              pixel_tick,
  input  logic              active_area_in,
  input  logic [size_x-1:0] pixel_x_in,
  input  logic [size_y-1:0] pixel_y_in,
  input  logic              printing,
  input  logic              count_finished,
  output logic [31:0]       data_reg,
  output logic              data_valid,
  output logic [ADDR_W-1:0] reg_index,
  output logic              active_area,
  output logic [size_x-1:0] pixel_x,
  output logic [size_y-1:0] pixel_y,
  output logic              scan_done,
  output logic              overrun
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_PRESENT    = 3'd1,
    S_CHECK      = 3'd2,
    S_WAIT_PRINT = 3'd3,
    S_DONE       = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  logic [31:0]       bank_q [NUM_REGS];
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [31:0]       data_reg_q, data_reg_d;
  logic [ADDR_W-1:0] reg_index_q, reg_index_d;
  logic              data_valid_q, data_valid_d;
  logic              scan_done_q, scan_done_d;
  logic              overrun_q, overrun_d;
  logic              active_area_q;
  logic [size_x-1:0] pixel_x_q;
  logic [size_y-1:0] pixel_y_q;
  logic              wr_hit;
  logic              new_scan;
  logic [31:0]       entry;

  generate
    if (NUM_REGS < (1 << ADDR_W)) begin : g_partial_decode
      assign wr_hit = wr_en && (32'(wr_addr) < 32'(NUM_REGS));
    end else begin : g_full_decode
      assign wr_hit = wr_en;
    end
  endgenerate

  // Scan reads bank_q before this edge's write lands, so a colliding write is seen next pass.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) bank_q[i] <= '0;
    end else if (wr_hit) begin
      bank_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_area_q <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
    end else if (pixel_tick) begin
      active_area_q <= active_area_in;
      pixel_x_q     <= pixel_x_in;
      pixel_y_q     <= pixel_y_in;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    data_reg_d   = data_reg_q;
    reg_index_d  = reg_index_q;
    data_valid_d = data_valid_q;
    overrun_d    = 1'b0;
    entry        = bank_q[idx_q];
    new_scan     = pixel_tick && active_area_in;

    case (state_q)
      S_IDLE: begin
        data_valid_d = 1'b0;
        if (new_scan) begin
          idx_d   = '0;
          state_d = S_PRESENT;
        end
      end
      S_PRESENT, S_CHECK: begin
        if (new_scan) begin
          overrun_d    = 1'b1;
          data_valid_d = 1'b0;
          idx_d        = '0;
          state_d      = S_PRESENT;
        end else if (state_q == S_PRESENT && entry[ENABLE_BIT]) begin
          data_reg_d   = entry;
          reg_index_d  = idx_q;
          data_valid_d = 1'b1;
          state_d      = S_CHECK;
        end else if (state_q == S_CHECK && printing) begin
          state_d = S_WAIT_PRINT;
        end else begin
          data_valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_PRESENT;
          end
        end
      end
      S_WAIT_PRINT: begin
        if (count_finished) begin
          data_valid_d = 1'b0;
          state_d      = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    scan_done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      data_reg_q   <= '0;
      reg_index_q  <= '0;
      data_valid_q <= 1'b0;
      scan_done_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      data_reg_q   <= data_reg_d;
      reg_index_q  <= reg_index_d;
      data_valid_q <= data_valid_d;
      scan_done_q  <= scan_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign data_reg    = data_reg_q;
  assign data_valid  = data_valid_q;
  assign reg_index   = reg_index_q;
  assign active_area = active_area_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign scan_done   = scan_done_q;
  assign overrun     = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_sprite_register_scanner.sv
// ----------------------------------------------------------------------------
// tb_sprite_register_scanner: scoreboard bench for sprite_register_scanner.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sprite_register_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic        pixel_tick;
  logic        active_area_in;
  logic [9:0]  pixel_x_in;
  logic [8:0]  pixel_y_in;
  logic        printing;
  logic        count_finished;
  logic [31:0] data_reg;
  logic        data_valid;
  logic [2:0]  reg_index;
  logic        active_area;
  logic [9:0]  pixel_x;
  logic [8:0]  pixel_y;
  logic        scan_done;
  logic        overrun;

  sprite_register_scanner dut (
    .clk            (clk),
    .reset          (reset),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .pixel_tick     (pixel_tick),
    .active_area_in (active_area_in),
    .pixel_x_in     (pixel_x_in),
    .pixel_y_in     (pixel_y_in),
    .printing       (printing),
    .count_finished (count_finished),
    .data_reg       (data_reg),
    .data_valid     (data_valid),
    .reg_index      (reg_index),
    .active_area    (active_area),
    .pixel_x        (pixel_x),
    .pixel_y        (pixel_y),
    .scan_done      (scan_done),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  idx;
  } pres_t;

  pres_t       pres_q [$];
  int          done_q [$];
  int          ovr_q  [$];
  logic [31:0] shadow [8];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_pres_obs = 0, n_pres_exp = 0;
  int n_done_obs = 0, n_done_exp = 0;
  int n_ovr_obs = 0, n_ovr_exp = 0;
  int n_valid_cyc = 0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output monitor: sampled on the falling edge, pops scoreboard entries as events appear.
  initial begin : monitor
    logic  prev_valid;
    pres_t p;
    int    c;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (data_valid) n_valid_cyc++;
      if (data_valid && !prev_valid) begin
        n_pres_obs++;
        if (pres_q.size() > 0) begin
          p = pres_q.pop_front();
          check_value("present_data", data_reg, p.data);
          check_value("present_index", 32'(reg_index), 32'(p.idx));
        end
      end
      prev_valid = data_valid;
      if (scan_done) begin
        n_done_obs++;
        if (done_q.size() > 0) begin
          c = done_q.pop_front();
          check_value("scan_done_cycle", cyc, c);
        end
      end
      if (overrun) begin
        n_ovr_obs++;
        if (ovr_q.size() > 0) begin
          c = ovr_q.pop_front();
          check_value("overrun_cycle", cyc, c);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_reg(input int a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a[2:0];
    wr_data = d;
    step(1);
    wr_en   = 1'b0;
    shadow[a] = d;
  endtask

  task automatic tick(input int x, input int y, input logic act, output int edge_no);
    pixel_tick     = 1'b1;
    active_area_in = act;
    pixel_x_in     = x[9:0];
    pixel_y_in     = y[8:0];
    step(1);
    edge_no    = cyc;
    pixel_tick = 1'b0;
  endtask

  // Starts a scan nobody claims; expected presentations and done cycle come from the shadow bank.
  task automatic start_scan(input int x, input int y, output int edge_no);
    int len;
    pres_t p;
    tick(x, y, 1'b1, edge_no);
    len = 0;
    for (int i = 0; i < 8; i++) begin
      if (shadow[i][31]) begin
        p.data = shadow[i];
        p.idx  = 3'(i);
        pres_q.push_back(p);
        n_pres_exp++;
        len += 2;
      end else begin
        len += 1;
      end
    end
    done_q.push_back(edge_no + len);
    n_done_exp++;
  endtask

  task automatic claim_next();
    for (int i = 0; i < 40 && !data_valid; i++) step(1);
    check_value("claim_wait_valid", 32'(data_valid), 32'd1);
    printing = 1'b1;
    step(1);
    printing = 1'b0;
  endtask

  initial begin
    int te, ta, vbase;
    pres_t p;
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    pixel_tick = 1'b0; active_area_in = 1'b0; pixel_x_in = '0; pixel_y_in = '0;
    printing = 1'b0; count_finished = 1'b0;
    for (int i = 0; i < 8; i++) shadow[i] = '0;

    // 1: reset state and an empty-bank scan
    #40;
    check_value("rst_data_reg", data_reg, 32'd0);
    check_value("rst_outputs", {21'd0, data_valid, reg_index, active_area, scan_done, overrun},
                32'd0);
    check_value("rst_pixel", {13'd0, pixel_x, pixel_y}, 32'd0);
    reset = 1'b1;
    step(2);
    start_scan(3, 4, te);
    step(12);
    check_value("t1_pixel_x", 32'(pixel_x), 32'd3);
    check_value("t1_done_count", n_done_obs, n_done_exp);
    check_value("t1_present_count", n_pres_obs, n_pres_exp);

    // 2: all entries enabled, nothing claimed
    for (int i = 0; i < 8; i++) write_reg(i, 32'h8000_0000 | i);
    vbase = n_valid_cyc;
    start_scan(100, 50, te);
    step(20);
    check_value("t2_valid_cycles", n_valid_cyc - vbase, 32'd8);
    check_value("t2_pixel_x", 32'(pixel_x), 32'd100);
    check_value("t2_pixel_y", 32'(pixel_y), 32'd50);
    check_value("t2_active_area", 32'(active_area), 32'd1);
    check_value("t2_done_count", n_done_obs, n_done_exp);

    // 3: single enabled entry claimed by the print stage
    for (int i = 0; i < 8; i++) write_reg(i, (i == 5) ? 32'h8001_2345 : 32'(i));
    tick(100, 60, 1'b1, te);
    p.data = 32'h8001_2345; p.idx = 3'd5;
    pres_q.push_back(p);
    n_pres_exp++;
    claim_next();
    step(2);
    check_value("t3_hold_data", data_reg, 32'h8001_2345);
    check_value("t3_hold_index", 32'(reg_index), 32'd5);
    check_value("t3_hold_valid", 32'(data_valid), 32'd1);

    // 4: writes and ticks while waiting on the line counter
    write_reg(5, 32'd0);
    for (int x = 100; x < 120; x++) begin
      tick(x, 60, 1'b1, ta);
      check_value("t4_pixel_x", 32'(pixel_x), 32'(x));
      check_value("t4_data_reg", data_reg, 32'h8001_2345);
      step(2);
    end
    check_value("t4_no_overrun", n_ovr_obs, n_ovr_exp);
    check_value("t4_still_valid", 32'(data_valid), 32'd1);
    count_finished = 1'b1;
    step(1);
    count_finished = 1'b0;
    done_q.push_back(cyc);
    n_done_exp++;
    check_value("t4_valid_drop", 32'(data_valid), 32'd0);
    step(3);
    start_scan(7, 8, te);
    step(12);
    check_value("t4_done_count", n_done_obs, n_done_exp);

    // 5: second tick three cycles into a scan
    write_reg(2, 32'h8000_0022);
    tick(10, 20, 1'b1, ta);
    step(2);
    start_scan(200, 70, te);
    ovr_q.push_back(te);
    n_ovr_exp++;
    check_value("t5_tick_gap", te - ta, 32'd3);
    step(15);
    check_value("t5_overrun_count", n_ovr_obs, n_ovr_exp);
    check_value("t5_done_count", n_done_obs, n_done_exp);
    check_value("t5_pixel_x", 32'(pixel_x), 32'd200);

    // 6: asynchronous reset while an entry is claimed
    tick(30, 30, 1'b1, te);
    p.data = 32'h8000_0022; p.idx = 3'd2;
    pres_q.push_back(p);
    n_pres_exp++;
    claim_next();
    step(1);
    #2;
    reset = 1'b0;
    #1;
    check_value("t6_rst_valid", 32'(data_valid), 32'd0);
    check_value("t6_rst_data", data_reg, 32'd0);
    check_value("t6_rst_done", 32'(scan_done), 32'd0);
    check_value("t6_rst_pixel_x", 32'(pixel_x), 32'd0);
    for (int i = 0; i < 8; i++) shadow[i] = '0;
    step(2);
    reset = 1'b1;
    step(2);
    start_scan(5, 5, te);
    step(14);

    check_value("final_present_count", n_pres_obs, n_pres_exp);
    check_value("final_done_count", n_done_obs, n_done_exp);
    check_value("final_overrun_count", n_ovr_obs, n_ovr_exp);
    check_value("final_queues_empty", pres_q.size() + done_q.size() + ovr_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
